// File: rtl/adder_stream_wrap.sv
// Valid/ready + credit wrapper around a 4-stage byte-sliced adder core: skews operands in, deskews sums out, FIFOs results.
// fire -> out_valid in 5 cycles; in_ready drops while DEPTH ops are outstanding. Optional out_ovf under ADD_OVF_FLAG_EN.
module adder_stream_wrap #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        in_cin,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  output logic        add_cin,
  input  logic [31:0] add_sum,
  input  logic        add_cout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_sum,
  output logic        out_cout
`ifdef ADD_OVF_FLAG_EN
  ,
  output logic        out_ovf
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
`ifdef ADD_OVF_FLAG_EN
    logic        ovf;
`endif
    logic        cout;
    logic [31:0] sum;
  } res_t;

  logic            fire;
  logic            pop;
  logic            wr_en;
  logic [CW-1:0]   occ_q, occ_d;
  logic [7:0]      a2_q, b2_q;
  logic [1:0][7:0] a3_q, b3_q;
  logic [3:0]      v_q;
  logic [2:0][7:0] d0_q;
  logic [1:0][7:0] d1_q;
  logic [7:0]      d2_q;
  res_t            wr_dat;
  res_t            mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  assign fire     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;
  assign wr_en    = v_q[3];
  assign in_ready = (occ_q < CW'(DEPTH)) && !reset;

  // Low half goes straight to the core; upper bytes trail by one and two cycles.
  assign add_a   = {a3_q[1], a2_q, fire ? in_a[15:0] : 16'h0000};
  assign add_b   = {b3_q[1], b2_q, fire ? in_b[15:0] : 16'h0000};
  assign add_cin = fire && in_cin;

  always_comb begin
    occ_d = occ_q;
    if (fire && !pop)      occ_d = occ_q + CW'(1);
    else if (!fire && pop) occ_d = occ_q - CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_q <= '0;
      a2_q  <= '0;
      b2_q  <= '0;
      a3_q  <= '0;
      b3_q  <= '0;
      v_q   <= '0;
      d0_q  <= '0;
      d1_q  <= '0;
      d2_q  <= '0;
    end else begin
      occ_q <= occ_d;
      a2_q  <= fire ? in_a[23:16] : 8'h00;
      b2_q  <= fire ? in_b[23:16] : 8'h00;
      a3_q  <= {a3_q[0], fire ? in_a[31:24] : 8'h00};
      b3_q  <= {b3_q[0], fire ? in_b[31:24] : 8'h00};
      v_q   <= {v_q[2:0], fire};
      d0_q  <= {d0_q[1:0], v_q[0] ? add_sum[7:0] : 8'h00};
      d1_q  <= {d1_q[0], v_q[1] ? add_sum[15:8] : 8'h00};
      d2_q  <= v_q[2] ? add_sum[23:16] : 8'h00;
    end
  end

`ifdef ADD_OVF_FLAG_EN
  logic [3:0][1:0] sg_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sg_q <= '0;
    else       sg_q <= {sg_q[2:0], fire ? {in_a[31], in_b[31]} : 2'b00};
  end
`endif

  // Byte 3 and carry arrive from the core in the same cycle the word completes.
  always_comb begin
    wr_dat      = '0;
    wr_dat.sum  = {add_sum[31:24], d2_q, d1_q[1], d0_q[2]};
    wr_dat.cout = add_cout;
`ifdef ADD_OVF_FLAG_EN
    wr_dat.ovf  = (sg_q[3][1] == sg_q[3][0]) && (add_sum[31] != sg_q[3][1]);
`endif
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_en) wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
    if (pop)   rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
    if (wr_en && !pop)      cnt_d = cnt_q + CW'(1);
    else if (!wr_en && pop) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr_en) mem_q[wr_ptr_q] <= wr_dat;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid = (cnt_q != '0);
  assign out_sum   = mem_q[rd_ptr_q].sum;
  assign out_cout  = mem_q[rd_ptr_q].cout;
`ifdef ADD_OVF_FLAG_EN
  assign out_ovf   = mem_q[rd_ptr_q].ovf;
`endif

endmodule

// File: tb/tb_adder_stream_wrap.sv
// Bench for adder_stream_wrap: byte-sliced core model, queue-based result model, directed and random traffic.
module tb_adder_stream_wrap;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b;
  logic        in_cin;
  logic [31:0] add_a, add_b, add_sum;
  logic        add_cin, add_cout;
  logic        out_valid, out_ready;
  logic [31:0] out_sum;
  logic        out_cout;
`ifdef ADD_OVF_FLAG_EN
  logic        out_ovf;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pops  = 0;
  int last_fire_cyc = 0;

  adder_stream_wrap #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout)
`ifdef ADD_OVF_FLAG_EN
    , .out_ovf(out_ovf)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Core: low half + cin at E0, byte 2 at E1, byte 3 at E2; sum byte k visible after Ek, cout after E3.
  logic [16:0] p0_q;
  logic [8:0]  p1_q, p2_q;
  logic [7:0]  s0_q, s1_q, s2_q, s3_q;
  logic        co_q;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      p0_q <= '0; p1_q <= '0; p2_q <= '0;
      s0_q <= '0; s1_q <= '0; s2_q <= '0; s3_q <= '0; co_q <= 1'b0;
    end else begin
      p0_q <= {1'b0, add_a[15:0]} + {1'b0, add_b[15:0]} + {16'h0000, add_cin};
      s0_q <= add_a[7:0] + add_b[7:0] + {7'h00, add_cin};
      s1_q <= p0_q[15:8];
      p1_q <= {1'b0, add_a[23:16]} + {1'b0, add_b[23:16]} + {8'h00, p0_q[16]};
      s2_q <= p1_q[7:0];
      p2_q <= {1'b0, add_a[31:24]} + {1'b0, add_b[31:24]} + {8'h00, p1_q[8]};
      s3_q <= p2_q[7:0];
      co_q <= p2_q[8];
    end
  end
  assign add_sum  = {s3_q, s2_q, s1_q, s0_q};
  assign add_cout = co_q;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: every accepted op is owed {cout,sum} = a+b+cin, in order, no earlier than 5 cycles later.
  typedef struct {
    logic [32:0] res;
    logic        ovf;
    int          cyc;
  } exp_t;
  exp_t q[$];

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      q.delete();
    end else begin
      chk("in_ready", {63'd0, in_ready}, {63'd0, q.size() < DEPTH});
      chk("out_valid", {63'd0, out_valid}, {63'd0, (q.size() != 0) && (cyc >= q[0].cyc + 5)});
      if (out_valid && q.size() != 0) begin
        chk("out_dat", {31'd0, out_cout, out_sum}, {31'd0, q[0].res});
`ifdef ADD_OVF_FLAG_EN
        chk("out_ovf", {63'd0, out_ovf}, {63'd0, q[0].ovf});
`endif
        if (out_ready) begin
          void'(q.pop_front());
          pops++;
        end
      end
      if (in_valid && in_ready) begin
        exp_t e;
        e.res = {1'b0, in_a} + {1'b0, in_b} + {32'd0, in_cin};
        e.ovf = (in_a[31] == in_b[31]) && (e.res[31] != in_a[31]);
        e.cyc = cyc;
        q.push_back(e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the op.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic c, output int stalls);
    int n = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = c;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n == 100) chk("send_wait", {63'd0, in_ready}, 64'd1);
    stalls = n;
    last_fire_cyc = cyc;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_res(input string name, input logic [31:0] esum, input logic ecout, input logic eovf);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk({name, "_lat"}, 64'(cyc - last_fire_cyc), 64'd5);
    chk({name, "_sum"}, {32'd0, out_sum}, {32'd0, esum});
    chk({name, "_cout"}, {63'd0, out_cout}, {63'd0, ecout});
`ifdef ADD_OVF_FLAG_EN
    chk({name, "_ovf"}, {63'd0, out_ovf}, {63'd0, eovf});
`else
    if (eovf) $display("note: ovf expectation ignored in this build");
`endif
    step();
  endtask

  function automatic logic [31:0] rnd();
    case ($urandom_range(0, 4))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not reach summary");
    $fatal(1);
  end

  initial begin
    int st, stalls, p0, acc, k, nv;
    logic [31:0] ta [10];
    logic [31:0] tb_ [10];
    logic acc_now;

    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("rst_add_a", {32'd0, add_a}, 64'd0);
    chk("rst_add_b", {32'd0, add_b}, 64'd0);
    chk("rst_add_cin", {63'd0, add_cin}, 64'd0);
    chk("rst_out_sum", {32'd0, out_sum}, 64'd0);
    chk("rst_out_cout", {63'd0, out_cout}, 64'd0);
    repeat (2) step();
    reset = 1'b0;
    @(negedge clk);
    chk("rdy_after_rst", {63'd0, in_ready}, 64'd1);
    step();

    send(32'h0000_00FF, 32'h0000_0001, 1'b0, st);
    wait_res("single", 32'h0000_0100, 1'b0, 1'b0);
    send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, st);
    wait_res("ripple", 32'h0000_0000, 1'b1, 1'b0);

    stalls = 0;
    p0 = pops;
    for (int i = 0; i < 16; i++) begin
      send(32'(i) * 32'h0101_0101, 32'hFF00_FF00 + 32'(i), i[0], st);
      stalls += st;
    end
    repeat (10) step();
    chk("b2b_stalls", 64'(stalls), 64'd0);
    chk("b2b_pops", 64'(pops - p0), 64'd16);

    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ta[i] = rnd();
      tb_[i] = rnd();
    end
    acc = 0; k = 0;
    for (int t = 0; t < 30 && k < 10; t++) begin
      in_valid = 1'b1; in_a = ta[k]; in_b = tb_[k]; in_cin = 1'b0;
      @(negedge clk);
      if (in_ready) begin
        acc++;
        k++;
      end
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("full_accepts", 64'(acc), 64'd8);
    chk("full_rdy", {63'd0, in_ready}, 64'd0);
    chk("hold_first_a", {31'd0, out_cout, out_sum}, {31'd0, {1'b0, ta[0]} + {1'b0, tb_[0]}});
    repeat (5) @(negedge clk);
    chk("hold_first_b", {31'd0, out_cout, out_sum}, {31'd0, {1'b0, ta[0]} + {1'b0, tb_[0]}});
    step();
    out_ready = 1'b1;
    p0 = pops;
    @(negedge clk);
    chk("rdy_before_pop", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    chk("rdy_after_pop", {63'd0, in_ready}, 64'd1);
    repeat (12) @(negedge clk);
    chk("drain_pops", 64'(pops - p0), 64'd8);
    step();

    for (int i = 0; i < 3; i++) send(rnd(), rnd(), 1'b1, st);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_rdy", {63'd0, in_ready}, 64'd0);
    chk("rst_mid_vld", {63'd0, out_valid}, 64'd0);
    repeat (2) step();
    reset = 1'b0;
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) nv++;
      step();
    end
    chk("stale_vld", 64'(nv), 64'd0);
    send(32'h1234_5678, 32'h1111_1111, 1'b0, st);
    wait_res("post_rst", 32'h2345_6789, 1'b0, 1'b0);

`ifdef ADD_OVF_FLAG_EN
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, st);
    wait_res("ovf_pos", 32'h8000_0000, 1'b0, 1'b1);
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, st);
    wait_res("ovf_none", 32'h0000_0000, 1'b1, 1'b0);
`endif

    acc_now = 1'b0;
    for (int t = 0; t < 400; t++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid || acc_now) begin
        in_valid = 1'($urandom_range(0, 1));
        in_a = rnd();
        in_b = rnd();
        in_cin = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      acc_now = in_valid && in_ready;
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (20) step();
    @(negedge clk);
    chk("end_vld", {63'd0, out_valid}, 64'd0);
    chk("end_rdy", {63'd0, in_ready}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adder_stream_wrap.md
Name: adder_stream_wrap

Overview:
- Streaming front/back end for the team's 4-stage byte-sliced pipelined 32-bit adder core.
- Accepts operand pairs on a valid/ready input and skews the upper operand bytes so the core can take a new add every cycle.
- Deskews the core's per-byte sum outputs back into whole words.
- Buffers results in a FIFO and returns them on a valid/ready output, with credit-based backpressure because the core itself cannot stall.

Parameters:
- DEPTH, 8, result FIFO entries and maximum outstanding ops (in flight plus buffered); legal range 2..64.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept an operand pair
- in_a  input  32  operand A
- in_b  input  32  operand B
- in_cin  input  1  carry in
- add_a  output  32  to core num_a
- add_b  output  32  to core num_b
- add_cin  output  1  to core Cin
- add_sum  input  32  from core SUM
- add_cout  input  1  from core Cout
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- out_sum  output  32  result sum
- out_cout  output  1  result carry out

Behaviour:
- One clock; reset is asynchronous and active-high. The core's reset is tied to the same reset net.
- fire = in_valid && in_ready. The edge that samples fire is E0; E1..E4 are the following edges.
- Core timing contract:
  - Core samples bytes [15:0] and Cin at E0, bytes [23:16] at E1, bytes [31:24] at E2.
  - Sum byte k becomes visible after edge Ek.
  - Cout becomes visible after E3.
- Input skew:
  - add_a/add_b[15:0] and add_cin are driven combinationally from in_a/in_b[15:0] and in_cin when fire=1, else 0.
  - Bytes [23:16] pass through a 1-stage register loaded at E0 (0 when no fire).
  - Bytes [31:24] pass through a 2-stage register chain.
  - Bubbles therefore present all-zero operands to the core.
- Valid tracking: 4-bit token shift register v. v[0] <= fire at each edge; v[k] <= v[k-1].
- Output deskew:
  - At the edge where v[k] is set for an op, capture add_sum byte k into that op's deskew slot.
  - Byte 0 is delayed 3 further stages, byte 1 two, byte 2 one.
  - Byte 3 and add_cout are captured at E4.
  - The assembled {sum, cout} is written into the FIFO at E4.
- Latency: fire in cycle 0 -> out_valid earliest in cycle 5.
- Throughput: 1 op/cycle while out_ready=1.
- Credits:
  - occ counter = ops accepted but not yet popped.
  - +1 on fire, -1 on out_valid && out_ready; both in the same cycle -> unchanged.
  - in_ready = (occ < DEPTH) && !reset. Because of this, the FIFO can never overflow.
- FIFO:
  - Order-preserving, registered head.
  - out_valid = FIFO not empty.
  - out_sum/out_cout stay stable while out_valid && !out_ready.
  - Pointers wrap modulo DEPTH.
- Arithmetic: {out_cout, out_sum} = in_a + in_b + in_cin, modulo 2^33.
- Reset values:
  - in_ready=0 while reset is high, 1 once it is released.
  - out_valid=0, out_sum=0, out_cout=0, add_*=0.
  - occ=0, v=0, all skew, deskew and FIFO registers 0.
- Reset mid-operation: all in-flight and buffered ops are discarded; no out_valid for them after release.

Optional Feature:
- Macro ADD_OVF_FLAG_EN.
- Defined:
  - Adds output port out_ovf (1 bit), reset 0.
  - Signed overflow = (a[31]==b[31]) && (sum[31]!=a[31]).
  - a[31] and b[31] are carried alongside the token to E4 and stored in the FIFO with the result.
- Undefined: port and logic absent; behaviour otherwise identical.

Test Plan:
- a=0x000000FF, b=0x00000001, cin=0, single op -> out_valid in cycle 5, sum=0x00000100, cout=0.
- a=0xFFFFFFFF, b=0x00000000, cin=1 -> sum=0x00000000, cout=1 (carry ripples through all four byte stages).
- 16 back-to-back ops, a=i*0x01010101, b=0xFF00FF00+i, cin=i[0], out_ready=1 -> in_ready never drops, 16 results on consecutive cycles, in order, each equal to a+b+cin.
- out_ready=0 with 10 ops offered -> exactly 8 accepted, in_ready=0 afterwards, first result held stable. Then out_ready=1 -> 8 results in order, in_ready reasserts on the first pop.
- 3 ops issued, reset asserted mid-flight for 2 cycles -> in_ready=0 and out_valid=0 during reset, no stale results afterwards. A following op 0x12345678+0x11111111 -> 0x23456789.
- With ADD_OVF_FLAG_EN defined:
  - 0x7FFFFFFF+0x00000001 -> sum 0x80000000, ovf=1, cout=0.
  - 0xFFFFFFFF+0x00000001 -> sum 0, ovf=0, cout=1.
